// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - instruction taps and stall/flush/md status of the hazard controller
interface pipe_hazard_ctrl_if;
    logic [31:0] instr_d;
    logic [31:0] instr_e;
    logic [31:0] instr_m;
    logic        stall;
    logic        flush_e;
    logic        md_busy;
    logic [3:0]  md_cnt;

    modport master (
        output instr_d, instr_e, instr_m,
        input  stall, flush_e, md_busy, md_cnt
    );

    modport slave (
        input  instr_d, instr_e, instr_m,
        output stall, flush_e, md_busy, md_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the five-stage MIPS pipeline
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [4:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_MULT, C_MULTU, C_DIV, C_DIVU,
        C_MFHI, C_MFLO, C_MTHI, C_MTLO, C_ORI, C_LW, C_SW, C_BEQ,
        C_LUI, C_J, C_JAL
    } op_class_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    function automatic op_class_e classify(input logic [5:0] op, input logic [5:0] funct);
        op_class_e c;
        c = C_NOP;
        if (op == 6'h00) begin
            case (funct)
                6'h21:   c = C_ADDU;
                6'h23:   c = C_SUBU;
                6'h08:   c = C_JR;
                6'h18:   c = C_MULT;
                6'h19:   c = C_MULTU;
                6'h1A:   c = C_DIV;
                6'h1B:   c = C_DIVU;
                6'h10:   c = C_MFHI;
                6'h12:   c = C_MFLO;
                6'h11:   c = C_MTHI;
                6'h13:   c = C_MTLO;
                default: c = C_NOP;
            endcase
        end else begin
            case (op)
                6'h0D:   c = C_ORI;
                6'h23:   c = C_LW;
                6'h2B:   c = C_SW;
                6'h04:   c = C_BEQ;
                6'h0F:   c = C_LUI;
                6'h02:   c = C_J;
                6'h03:   c = C_JAL;
                default: c = C_NOP;
            endcase
        end
        return c;
    endfunction

    // Destination register; 0 means "writes nothing that can hazard".
    function automatic logic [4:0] dest_reg(input op_class_e c, input logic [4:0] rt, input logic [4:0] rd);
        case (c)
            C_ADDU, C_SUBU, C_MFHI, C_MFLO: return rd;
            C_ORI, C_LW, C_LUI:             return rt;
            C_JAL:                          return 5'd31;
            default:                        return 5'd0;
        endcase
    endfunction

    // Cycles from D until rs is consumed; 3 means never needed.
    function automatic logic [1:0] tuse_rs(input op_class_e c);
        case (c)
            C_BEQ, C_JR:                                      return 2'd0;
            C_ADDU, C_SUBU, C_MULT, C_MULTU, C_DIV, C_DIVU,
            C_ORI, C_LW, C_MTHI, C_MTLO, C_SW:                return 2'd1;
            default:                                          return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] tuse_rt(input op_class_e c);
        case (c)
            C_BEQ:                                            return 2'd0;
            C_ADDU, C_SUBU, C_MULT, C_MULTU, C_DIV, C_DIVU:   return 2'd1;
            C_SW:                                             return 2'd2;
            default:                                          return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] tnew_in_e(input op_class_e c);
        case (c)
            C_LW:                                             return 2'd2;
            C_ADDU, C_SUBU, C_ORI, C_LUI, C_MFHI, C_MFLO:     return 2'd1;
            default:                                          return 2'd0;
        endcase
    endfunction

    function automatic logic is_md_start(input op_class_e c);
        return (c == C_MULT) || (c == C_MULTU) || (c == C_DIV) || (c == C_DIVU);
    endfunction

    function automatic logic is_md_user(input op_class_e c);
        return is_md_start(c) || (c == C_MFHI) || (c == C_MFLO) || (c == C_MTHI) || (c == C_MTLO);
    endfunction

    op_class_e  cls_d, cls_e, cls_m;
    logic [4:0] rs_d, rt_d, wr_e, wr_m;
    logic [1:0] tu_rs, tu_rt, tn_e, tn_m;
    logic       data_stall, md_stall;
    logic [3:0] md_cnt_q;
    logic       unused_fields;

    assign cls_d = classify(hz.instr_d[31:26], hz.instr_d[5:0]);
    assign cls_e = classify(hz.instr_e[31:26], hz.instr_e[5:0]);
    assign cls_m = classify(hz.instr_m[31:26], hz.instr_m[5:0]);

    assign rs_d  = hz.instr_d[25:21];
    assign rt_d  = hz.instr_d[20:16];
    assign wr_e  = dest_reg(cls_e, hz.instr_e[20:16], hz.instr_e[15:11]);
    assign wr_m  = dest_reg(cls_m, hz.instr_m[20:16], hz.instr_m[15:11]);

    assign tu_rs = tuse_rs(cls_d);
    assign tu_rt = tuse_rt(cls_d);
    assign tn_e  = tnew_in_e(cls_e);
    assign tn_m  = (cls_m == C_LW) ? 2'd1 : 2'd0;

    // Shift amounts and the rs fields of E/M play no part in hazard detection.
    assign unused_fields = ^{hz.instr_d[10:6], hz.instr_e[25:21], hz.instr_e[10:6],
                             hz.instr_m[25:21], hz.instr_m[10:6]};

    // RAW hazards the forwarding network cannot resolve in time.
    always_comb begin
        data_stall = 1'b0;
        if (rs_d != 5'd0) begin
            if ((rs_d == wr_e) && (tn_e > tu_rs)) data_stall = 1'b1;
            if ((rs_d == wr_m) && (tn_m > tu_rs)) data_stall = 1'b1;
        end
        if (rt_d != 5'd0) begin
            if ((rt_d == wr_e) && (tn_e > tu_rt)) data_stall = 1'b1;
            if ((rt_d == wr_m) && (tn_m > tu_rt)) data_stall = 1'b1;
        end
    end

    // HI/LO users wait while a multiply/divide is starting in E or still running.
    always_comb begin
        md_stall = is_md_user(cls_d) && ((md_cnt_q != 4'd0) || is_md_start(cls_e));
    end

    // Busy countdown; the E instruction always advances, so stall does not gate it.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= 4'd0;
        end else if ((cls_e == C_MULT) || (cls_e == C_MULTU)) begin
            md_cnt_q <= MULT_LOAD;
        end else if ((cls_e == C_DIV) || (cls_e == C_DIVU)) begin
            md_cnt_q <= DIV_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_q <= md_cnt_q - 4'd1;
        end
    end

    assign hz.stall   = data_stall | md_stall;
    assign hz.flush_e = data_stall | md_stall;
    assign hz.md_busy = (md_cnt_q != 4'd0);
    assign hz.md_cnt  = md_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] LW_8      = 32'h8C08_0000;
    localparam logic [31:0] LW_9      = 32'h8C09_0000;
    localparam logic [31:0] LW_0      = 32'h8C00_0000;
    localparam logic [31:0] ADDU_988  = 32'h0108_4821;
    localparam logic [31:0] BEQ_8_0   = 32'h1100_0000;
    localparam logic [31:0] BEQ_0_0   = 32'h1000_0000;
    localparam logic [31:0] MULT_45   = 32'h0085_0018;
    localparam logic [31:0] DIV_45    = 32'h0085_001A;
    localparam logic [31:0] MFLO_2    = 32'h0000_1012;
    localparam logic [31:0] MTLO_2    = 32'h0040_0013;
    localparam logic [31:0] JAL_0     = 32'h0C00_0000;
    localparam logic [31:0] ADDU_2_31 = 32'h03FF_1021;
    localparam logic [31:0] SW_8_9    = 32'hAD28_0000;
    localparam logic [31:0] ORI_8     = 32'h3408_0001;
    localparam logic [31:0] ORI_9     = 32'h3409_0001;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
        hz.instr_d = d;
        hz.instr_e = e;
        hz.instr_m = m;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(NOP, NOP, NOP);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_stall",   32'(hz.stall),   32'd0);
        check("reset_flush",   32'(hz.flush_e), 32'd0);
        check("reset_md_cnt",  32'(hz.md_cnt),  32'd0);
        check("reset_md_busy", 32'(hz.md_busy), 32'd0);

        drive(ADDU_988, LW_8, NOP);
        check("load_use_e_stall", 32'(hz.stall),   32'd1);
        check("load_use_e_flush", 32'(hz.flush_e), 32'd1);
        drive(ADDU_988, NOP, LW_8);
        check("load_use_m_stall", 32'(hz.stall),   32'd0);

        drive(BEQ_8_0, LW_8, NOP);
        check("load_br_e_stall", 32'(hz.stall), 32'd1);
        drive(BEQ_8_0, NOP, LW_8);
        check("load_br_m_stall", 32'(hz.stall), 32'd1);
        drive(BEQ_0_0, LW_0, NOP);
        check("load_br_r0",      32'(hz.stall), 32'd0);

        drive(MFLO_2, MULT_45, NOP);
        check("mult_in_e_stall", 32'(hz.stall),  32'd1);
        check("mult_in_e_cnt",   32'(hz.md_cnt), 32'd0);
        tick();
        drive(MFLO_2, NOP, NOP);
        for (int i = 5; i >= 1; i--) begin
            check("mult_cnt",   32'(hz.md_cnt),  32'(i));
            check("mult_busy",  32'(hz.md_busy), 32'd1);
            check("mult_stall", 32'(hz.stall),   32'd1);
            tick();
        end
        check("mult_done_cnt",   32'(hz.md_cnt),  32'd0);
        check("mult_done_busy",  32'(hz.md_busy), 32'd0);
        check("mult_done_stall", 32'(hz.stall),   32'd0);

        drive(NOP, DIV_45, NOP);
        tick();
        drive(NOP, NOP, NOP);
        check("div_load", 32'(hz.md_cnt), 32'd10);
        tick();
        tick();
        tick();
        check("div_cnt7", 32'(hz.md_cnt), 32'd7);
        reset = 1'b1;
        drive(NOP, DIV_45, NOP);
        tick();
        reset = 1'b0;
        drive(NOP, NOP, NOP);
        check("rst_mid_cnt",  32'(hz.md_cnt),  32'd0);
        check("rst_mid_busy", 32'(hz.md_busy), 32'd0);

        drive(NOP, DIV_45, NOP);
        tick();
        drive(NOP, NOP, NOP);
        tick();
        check("reload_pre", 32'(hz.md_cnt), 32'd9);
        drive(NOP, MULT_45, NOP);
        tick();
        drive(MTLO_2, NOP, NOP);
        check("reload_cnt",   32'(hz.md_cnt), 32'd5);
        check("mtlo_busy_st", 32'(hz.stall),  32'd1);

        drive(ADDU_2_31, JAL_0, NOP);
        check("jal_fwd", 32'(hz.stall), 32'd0);
        drive(SW_8_9, ORI_8, NOP);
        check("sw_rt_ori", 32'(hz.stall), 32'd0);
        drive(SW_8_9, ORI_9, NOP);
        check("sw_rs_ori", 32'(hz.stall), 32'd0);
        drive(SW_8_9, LW_8, NOP);
        check("sw_rt_lw",  32'(hz.stall), 32'd0);
        drive(SW_8_9, LW_9, NOP);
        check("sw_rs_lw",  32'(hz.stall), 32'd1);
        check("sw_rs_lw_flush", 32'(hz.flush_e), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
